// File: rtl/sample_history_capture_pkg.sv
// Shared types and helpers for the sample_history_capture block.
// Contents:
//   shc_state_e  - response FSM states (SHC_IDLE: no response pending,
//                  SHC_HOLD: response presented until consumed)
//   clog2_min1() - ceil(log2(n)), never less than 1, for index widths
// Optional feature macro used elsewhere in this block: SHC_TIMESTAMP_EN.
package shc_pkg;

  typedef enum logic {
    SHC_IDLE = 1'b0,
    SHC_HOLD = 1'b1
  } shc_state_e;

  // Width of an index able to address n items; a single item still gets a
  // 1-bit index so no port ever collapses to zero width.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sample_history_capture_if.sv
// Request/response bus of sample_history_capture.
// Signals:
//   req_valid  (master->slave) read request
//   req_ready  (slave->master) request accepted when valid && ready at posedge
//   req_ch     (master->slave) channel index, CW bits
//   req_age    (master->slave) history age, AW bits, 0 = newest sample
//   resp_valid (slave->master) response held until resp_ready
//   resp_ready (master->slave) consumer accepts the response
//   resp_data  (slave->master) sample value, 0 on error
//   resp_err   (slave->master) channel out of range or age beyond fill
//   resp_ts    (slave->master) capture timestamp, only with SHC_TIMESTAMP_EN
// Modports: master (requester / consumer side), slave (the capture block).
interface sample_history_capture_if
  import shc_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int W     = 8,
  parameter int DEPTH = 4
`ifdef SHC_TIMESTAMP_EN
  , parameter int TS_W = 32
`endif
) ();

  localparam int CW = clog2_min1(NCH);
  localparam int AW = clog2_min1(DEPTH);

  logic          req_valid;
  logic          req_ready;
  logic [CW-1:0] req_ch;
  logic [AW-1:0] req_age;
  logic          resp_valid;
  logic          resp_ready;
  logic [W-1:0]  resp_data;
  logic          resp_err;
`ifdef SHC_TIMESTAMP_EN
  logic [TS_W-1:0] resp_ts;
`endif

  modport master (
    output req_valid, req_ch, req_age, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
`ifdef SHC_TIMESTAMP_EN
    , input resp_ts
`endif
  );

  modport slave (
    input  req_valid, req_ch, req_age, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
`ifdef SHC_TIMESTAMP_EN
    , output resp_ts
`endif
  );

endinterface

// File: rtl/sample_history_capture_channel_hist.sv
// One channel's sample history: a DEPTH-deep shift register with a shift
// enable and a combinational read port addressed by age.
// With SHC_TIMESTAMP_EN each slot also carries the timestamp presented on
// ts_in at its capture edge, shifting alongside the data.
// Ports:
//   clk, rst_n - clock, synchronous active-low reset (clears all slots)
//   shift_en   - 1 = capture din into slot 0 and age every slot by one
//   din        - W-bit channel sample
//   ts_in      - current timestamp (SHC_TIMESTAMP_EN only)
//   rd_age     - slot to read, 0 = newest
//   rd_data    - slot contents, 0 for ages beyond DEPTH
//   rd_ts      - slot timestamp (SHC_TIMESTAMP_EN only)
module shc_channel_hist #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
`ifdef SHC_TIMESTAMP_EN
  , parameter int TS_W = 32
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            shift_en,
  input  logic [W-1:0]    din,
`ifdef SHC_TIMESTAMP_EN
  input  logic [TS_W-1:0] ts_in,
  output logic [TS_W-1:0] rd_ts,
`endif
  input  logic [AW-1:0]   rd_age,
  output logic [W-1:0]    rd_data
);

  logic [W-1:0] hist [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) hist[k] <= '0;
    end else if (shift_en) begin
      hist[0] <= din;
      for (int k = 1; k < DEPTH; k++) hist[k] <= hist[k-1];
    end
  end

  // Non-power-of-two depths leave unused age codes; they read as zero and
  // the top flags them as errors through the fill comparison.
  always_comb begin
    rd_data = '0;
    if (int'(rd_age) < DEPTH) rd_data = hist[rd_age];
  end

`ifdef SHC_TIMESTAMP_EN
  logic [TS_W-1:0] ts_hist [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) ts_hist[k] <= '0;
    end else if (shift_en) begin
      ts_hist[0] <= ts_in;
      for (int k = 1; k < DEPTH; k++) ts_hist[k] <= ts_hist[k-1];
    end
  end

  always_comb begin
    rd_ts = '0;
    if (int'(rd_age) < DEPTH) rd_ts = ts_hist[rd_age];
  end
`endif

endmodule

// File: rtl/sample_history_capture.sv
// Multi-channel synchronous input sampler with per-channel sample history.
// Every clk edge without freeze shifts all NCH channels into a DEPTH-deep
// history; a valid/ready request reads any (channel, age) sample and the
// answer appears on a registered response one cycle after acceptance.
// Optional feature: define SHC_TIMESTAMP_EN to add a free-running TS_W-bit
// counter whose value is stored with every captured sample and returned on
// resp_ts.
// Ports:
//   clk    - sole clock, rising edge
//   rst_n  - synchronous active-low reset
//   ch_in  - NCH*W bits, channel c at [c*W +: W]
//   freeze - 1 = history and fill hold, requests still served
//   bus    - sample_history_capture_if.slave request/response bus
module sample_history_capture
  import shc_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int W     = 8,
  parameter int DEPTH = 4
`ifdef SHC_TIMESTAMP_EN
  , parameter int TS_W = 32
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*W-1:0]     ch_in,
  input  logic                 freeze,
  sample_history_capture_if.slave bus
);

  localparam int CW    = clog2_min1(NCH);
  localparam int AW    = clog2_min1(DEPTH);
  localparam int FW    = $clog2(DEPTH + 1);
  localparam int NSLOT = 2 ** CW;

  shc_state_e   state;
  shc_state_e   state_next;
  logic [FW-1:0] fill;
  logic          accept;
  logic          req_ready;
  logic          resp_valid;
  logic          req_err;
  logic [W-1:0]  sel_data;
  logic [W-1:0]  resp_data;
  logic          resp_err;
  logic [W-1:0]  rd_data [NSLOT];

`ifdef SHC_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] sel_ts;
  logic [TS_W-1:0] resp_ts;
  logic [TS_W-1:0] rd_ts [NSLOT];

  // Free-running capture clock; wraps naturally at 2^TS_W.
  always_ff @(posedge clk) begin
    if (!rst_n) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + TS_W'(1);
  end
`endif

  // The read mux is sized to every code of req_ch; codes past NCH read zero
  // and are reported as errors by the decode below.
  for (genvar c = 0; c < NSLOT; c++) begin : g_ch
    if (c < NCH) begin : g_real
      shc_channel_hist #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
`ifdef SHC_TIMESTAMP_EN
        , .TS_W(TS_W)
`endif
      ) u_hist (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (!freeze),
        .din      (ch_in[c*W +: W]),
`ifdef SHC_TIMESTAMP_EN
        .ts_in    (ts_cnt),
        .rd_ts    (rd_ts[c]),
`endif
        .rd_age   (bus.req_age),
        .rd_data  (rd_data[c])
      );
    end else begin : g_pad
      assign rd_data[c] = '0;
`ifdef SHC_TIMESTAMP_EN
      assign rd_ts[c] = '0;
`endif
    end
  end

  // Number of valid history entries; saturates once the history is full.
  always_ff @(posedge clk) begin
    if (!rst_n)                               fill <= '0;
    else if (!freeze && fill != FW'(DEPTH))   fill <= fill + FW'(1);
  end

  // Request decode against the pre-edge history (old-value rule).
  always_comb begin
    req_err  = (int'(bus.req_ch) >= NCH) || (int'(bus.req_age) >= int'(fill));
    sel_data = rd_data[bus.req_ch];
`ifdef SHC_TIMESTAMP_EN
    sel_ts   = rd_ts[bus.req_ch];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= SHC_IDLE;
    else        state <= state_next;
  end

  // One-deep response slot: a new request is taken whenever the slot is
  // empty or is being emptied this very cycle.
  always_comb begin
    state_next = state;
    resp_valid = (state == SHC_HOLD);
    req_ready  = rst_n && (!resp_valid || bus.resp_ready);
    accept     = bus.req_valid && req_ready;
    case (state)
      SHC_IDLE: if (accept) state_next = SHC_HOLD;
      SHC_HOLD: begin
        if (accept)               state_next = SHC_HOLD;
        else if (bus.resp_ready)  state_next = SHC_IDLE;
      end
      default:                    state_next = SHC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_data <= '0;
      resp_err  <= 1'b0;
`ifdef SHC_TIMESTAMP_EN
      resp_ts   <= '0;
`endif
    end else if (accept) begin
      resp_err  <= req_err;
      resp_data <= req_err ? '0 : sel_data;
`ifdef SHC_TIMESTAMP_EN
      resp_ts   <= req_err ? '0 : sel_ts;
`endif
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_data  = resp_data;
  assign bus.resp_err   = resp_err;
`ifdef SHC_TIMESTAMP_EN
  assign bus.resp_ts    = resp_ts;
`endif

endmodule

// File: tb/tb_sample_history_capture.sv
// Self-checking bench for sample_history_capture (NCH=3 so that an
// out-of-range channel code exists). A reference model of the history, fill,
// timestamp counter and response slot predicts each response; predictions
// are queued at acceptance and compared when the response appears.
// Define SHC_TIMESTAMP_EN to also cover timestamps (TS_W=4 to see the wrap).
module tb_sample_history_capture;
  import shc_pkg::*;

  localparam int NCH   = 3;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int TS_W  = 4;
  localparam int CW    = clog2_min1(NCH);
  localparam int AW    = clog2_min1(DEPTH);

  typedef struct {
    logic            err;
    logic [W-1:0]    data;
    logic [TS_W-1:0] ts;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NCH*W-1:0] ch_in = '0;
  logic             freeze = 1'b0;

  sample_history_capture_if #(
    .NCH(NCH), .W(W), .DEPTH(DEPTH)
`ifdef SHC_TIMESTAMP_EN
    , .TS_W(TS_W)
`endif
  ) bus ();

  sample_history_capture #(
    .NCH(NCH), .W(W), .DEPTH(DEPTH)
`ifdef SHC_TIMESTAMP_EN
    , .TS_W(TS_W)
`endif
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ch_in  (ch_in),
    .freeze (freeze),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0]    hist_m [NCH][DEPTH];
  logic [TS_W-1:0] tsh_m  [NCH][DEPTH];
  int              fill_m = 0;
  logic [TS_W-1:0] ts_m = '0;
  logic            m_valid = 1'b0;
  exp_t            m_cur;
  exp_t            sb [$];

  int check_count = 0;
  int pass_count  = 0;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic set_channels(input int base);
    for (int c = 0; c < NCH; c++) ch_in[c*W +: W] = W'(base + 16 * c);
  endtask

  // One clock cycle: drive the request side, predict acceptance, advance the
  // model at the edge and compare outputs at the following falling edge.
  task automatic applyStimulus(input logic v, input int ch, input int age, input logic rdy);
    logic m_rdy;
    logic acc;
    exp_t e;
    bus.req_valid  = v;
    bus.req_ch     = CW'(ch);
    bus.req_age    = AW'(age);
    bus.resp_ready = rdy;
    #1;
    m_rdy = rst_n && (!m_valid || rdy);
    checkOutput("req_ready", {63'd0, bus.req_ready}, {63'd0, m_rdy});
    acc = v && m_rdy;
    if (acc) begin
      e.err  = (ch >= NCH) || (age >= fill_m);
      e.data = '0;
      e.ts   = '0;
      if (!e.err) begin
        e.data = hist_m[ch][age];
        e.ts   = tsh_m[ch][age];
      end
      sb.push_back(e);
    end
    @(posedge clk);
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < DEPTH; k++) begin
          hist_m[c][k] = '0;
          tsh_m[c][k]  = '0;
        end
      fill_m  = 0;
      ts_m    = '0;
      m_valid = 1'b0;
      sb.delete();
    end else begin
      if (!freeze) begin
        for (int c = 0; c < NCH; c++) begin
          for (int k = DEPTH - 1; k > 0; k--) begin
            hist_m[c][k] = hist_m[c][k-1];
            tsh_m[c][k]  = tsh_m[c][k-1];
          end
          hist_m[c][0] = ch_in[c*W +: W];
          tsh_m[c][0]  = ts_m;
        end
        if (fill_m < DEPTH) fill_m++;
      end
      ts_m = ts_m + TS_W'(1);
      if (!acc && m_valid && rdy) m_valid = 1'b0;
    end
    @(negedge clk);
    if (acc && rst_n) begin
      if (sb.size() == 0) checkOutput("sb_underflow", 64'd1, 64'd0);
      else begin
        m_cur   = sb.pop_front();
        m_valid = 1'b1;
      end
    end
    checkOutput("resp_valid", {63'd0, bus.resp_valid}, {63'd0, m_valid});
    if (m_valid) begin
      checkOutput("resp_data", 64'(bus.resp_data), 64'(m_cur.data));
      checkOutput("resp_err", {63'd0, bus.resp_err}, {63'd0, m_cur.err});
`ifdef SHC_TIMESTAMP_EN
      checkOutput("resp_ts", 64'(bus.resp_ts), 64'(m_cur.ts));
`endif
    end
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_ch     = '0;
    bus.req_age    = '0;
    bus.resp_ready = 1'b1;

    // Reset, then a 5-edge ramp and a read of the newest ch0 sample
    rst_n = 1'b0;
    applyStimulus(1'b0, 0, 0, 1'b1);
    applyStimulus(1'b1, 0, 0, 1'b1);
    checkOutput("rst_resp_data", 64'(bus.resp_data), 64'd0);
    checkOutput("rst_resp_err", {63'd0, bus.resp_err}, 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_channels(i);
      applyStimulus(1'b0, 0, 0, 1'b1);
    end
    set_channels(5);
    applyStimulus(1'b1, 0, 0, 1'b1);
    checkOutput("t1_data", 64'(bus.resp_data), 64'h04);
    checkOutput("t1_err", {63'd0, bus.resp_err}, 64'd0);
    applyStimulus(1'b0, 0, 0, 1'b1);

    // Two shifts then frozen reads: valid age, age beyond fill, bad channel
    rst_n = 1'b0;
    applyStimulus(1'b0, 0, 0, 1'b1);
    rst_n = 1'b1;
    set_channels(8'hA0);
    applyStimulus(1'b0, 0, 0, 1'b1);
    set_channels(8'hC0);
    applyStimulus(1'b0, 0, 0, 1'b1);
    freeze = 1'b1;
    applyStimulus(1'b1, 1, 1, 1'b1);
    checkOutput("t2_age1", 64'(bus.resp_data), 64'hB0);
    applyStimulus(1'b1, 1, 2, 1'b1);
    checkOutput("t2_age2_err", {63'd0, bus.resp_err}, 64'd1);
    applyStimulus(1'b1, NCH, 0, 1'b1);
    checkOutput("t2_ch_err", {63'd0, bus.resp_err}, 64'd1);
    freeze = 1'b0;
    applyStimulus(1'b0, 0, 0, 1'b1);

    // Fill the history, then freeze for 10 cycles while inputs keep moving
    for (int i = 0; i < 4; i++) begin
      set_channels(8'h40 + i);
      applyStimulus(1'b0, 0, 0, 1'b1);
    end
    freeze = 1'b1;
    for (int k = 0; k < 10; k++) begin
      set_channels(8'h80 + k);
      if (k >= 1 && k <= 4) applyStimulus(1'b1, 0, k - 1, 1'b1);
      else                  applyStimulus(1'b0, 0, 0, 1'b1);
      if (k == 1) checkOutput("t3_frozen_age0", 64'(bus.resp_data), 64'h43);
    end
    freeze = 1'b0;

    // Back-pressure for 3 cycles, then full-rate back-to-back requests
    set_channels(8'h20);
    applyStimulus(1'b1, 2, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      set_channels(8'h21 + k);
      applyStimulus(1'b1, 1, 1, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      set_channels(8'h30 + k);
      applyStimulus(1'b1, k % NCH, k, 1'b1);
    end
    applyStimulus(1'b0, 0, 0, 1'b1);

    // Reset while a response is held
    applyStimulus(1'b1, 0, 0, 1'b0);
    rst_n = 1'b0;
    applyStimulus(1'b0, 0, 0, 1'b0);
    checkOutput("t5_valid_after_rst", {63'd0, bus.resp_valid}, 64'd0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 0, 0, 1'b1);
    checkOutput("t5_err_empty", {63'd0, bus.resp_err}, 64'd1);
    applyStimulus(1'b0, 0, 0, 1'b1);

`ifdef SHC_TIMESTAMP_EN
    // Sample captured at counter 7 is read at age 2 two shifts later
    rst_n = 1'b0;
    applyStimulus(1'b0, 0, 0, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_channels(8'h50 + i);
      applyStimulus(1'b0, 0, 0, 1'b1);
    end
    freeze = 1'b1;
    applyStimulus(1'b1, 0, 2, 1'b1);
    checkOutput("t6_ts7", 64'(bus.resp_ts), 64'd7);
    freeze = 1'b0;
    // Run past the 4-bit wrap and read back timestamps on both sides of it
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 0, 0, 1'b1);
    freeze = 1'b1;
    for (int a = 0; a < DEPTH; a++) applyStimulus(1'b1, 1, a, 1'b1);
    freeze = 1'b0;
    applyStimulus(1'b0, 0, 0, 1'b1);
`endif

    checkOutput("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
